// File: rtl/video_pkg.sv
// Shared video constants: pattern codes, source FSM encoding, and the colour-mode /
// operation codes the scanout stage also decodes.
package video_pkg;

    localparam logic [1:0] PAT_SOLID = 2'd0;
    localparam logic [1:0] PAT_GRAD  = 2'd1;
    localparam logic [1:0] PAT_CHECK = 2'd2;
    localparam logic [1:0] PAT_BARS  = 2'd3;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_STREAM = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    localparam logic [1:0] CMODE_RGB888 = 2'd0;
    localparam logic [1:0] CMODE_RGB565 = 2'd1;
    localparam logic [1:0] CMODE_YUV422 = 2'd2;
    localparam logic [1:0] CMODE_MONO8  = 2'd3;

    localparam logic [1:0] OP_PASS    = 2'd0;
    localparam logic [1:0] OP_OVERLAY = 2'd1;
    localparam logic [1:0] OP_BLEND   = 2'd2;
    localparam logic [1:0] OP_FILL    = 2'd3;

endpackage

// File: rtl/video_pattern_gen.sv
// Combinational test-pattern word generator; maps word coordinates and pattern
// select to one 32-bit packed pixel group. Also used by the scanout test overlay.
module video_pattern_gen
    import video_pkg::*;
#(
    parameter int BAR_SHIFT   = 4,
    parameter int CHECK_SHIFT = 3
) (
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic [1:0]  pattern,
    input  logic [31:0] solid_color,
    output logic [31:0] word
);

    logic [2:0] bar;
    logic       unused_ok;

    assign bar       = x[BAR_SHIFT+2:BAR_SHIFT];
    assign unused_ok = ^{x[15:8], y[15:8]};

    // Bars are BGR byte order: blue lands in [23:16].
    always_comb begin
        word = solid_color;
        case (pattern)
            PAT_GRAD:  word = {8'h00, x[7:0], y[7:0], x[7:0] ^ y[7:0]};
            PAT_CHECK: word = (x[CHECK_SHIFT] ^ y[CHECK_SHIFT]) ? 32'hFFFF_FFFF : 32'h0;
            PAT_BARS:  word = {8'h00, {8{bar[2]}}, {8{bar[1]}}, {8{bar[0]}}};
            default:   word = solid_color;
        endcase
    end

endmodule

// File: rtl/video_stream_source.sv
// AXI4-Stream raster video source: on a frame request, streams W x H pattern words
// with tuser on the first word of the frame and tlast on the last word of each line.
module video_stream_source
    import video_pkg::*;
#(
    parameter int          BAR_SHIFT   = 4,
    parameter int          CHECK_SHIFT = 3,
    parameter logic [31:0] FILL_COLOR  = 32'h00FF00FF
) (
    input  logic        m_axis_vid_aclk,
    input  logic        aresetn,
    input  logic        enable,
    input  logic        frame_req,
    input  logic [15:0] cfg_width,
    input  logic [15:0] cfg_height,
    input  logic [1:0]  cfg_pattern,
    input  logic [31:0] cfg_color,
    input  logic        cfg_color_we,
    output logic [31:0] m_axis_vid_tdata,
    output logic        m_axis_vid_tvalid,
    input  logic        m_axis_vid_tready,
    output logic        m_axis_vid_tlast,
    output logic        m_axis_vid_tuser,
    output logic        frame_done,
    output logic [15:0] frame_count,
    output logic        busy,
    output logic        req_dropped
);

    logic [1:0]  state;
    logic [15:0] x, y;
    logic [15:0] w_q, h_q;
    logic [1:0]  pat_q;
    logic [31:0] solid_color;

    logic        start, xfer, x_end, last;
    logic [15:0] x_nxt, y_nxt;
    logic [1:0]  pat_sel;
    logic [31:0] color_nxt, word_nxt;

    assign start = (state == ST_IDLE) && enable && frame_req &&
                   (cfg_width != 16'd0) && (cfg_height != 16'd0);
    assign xfer  = (state == ST_STREAM) && m_axis_vid_tvalid && m_axis_vid_tready;
    assign x_end = (x == w_q - 16'd1);
    assign last  = x_end && (y == h_q - 16'd1);
    assign busy  = (state != ST_IDLE);

    always_comb begin
        x_nxt = x + 16'd1;
        y_nxt = y;
        if (start) begin
            x_nxt = 16'd0;
            y_nxt = 16'd0;
        end else if (x_end) begin
            x_nxt = 16'd0;
            y_nxt = y + 16'd1;
        end
    end

    // The first word is built before the shadow registers load, so it uses the live config.
    assign pat_sel   = start ? cfg_pattern : pat_q;
    assign color_nxt = cfg_color_we ? cfg_color : solid_color;

    video_pattern_gen #(
        .BAR_SHIFT  (BAR_SHIFT),
        .CHECK_SHIFT(CHECK_SHIFT)
    ) u_pattern_gen (
        .x          (x_nxt),
        .y          (y_nxt),
        .pattern    (pat_sel),
        .solid_color(color_nxt),
        .word       (word_nxt)
    );

    always_ff @(posedge m_axis_vid_aclk or negedge aresetn) begin
        if (!aresetn) begin
            state             <= ST_IDLE;
            x                 <= 16'd0;
            y                 <= 16'd0;
            w_q               <= 16'd0;
            h_q               <= 16'd0;
            pat_q             <= PAT_SOLID;
            solid_color       <= FILL_COLOR;
            m_axis_vid_tdata  <= 32'h0;
            m_axis_vid_tvalid <= 1'b0;
            m_axis_vid_tlast  <= 1'b0;
            m_axis_vid_tuser  <= 1'b0;
            frame_done        <= 1'b0;
            frame_count       <= 16'd0;
            req_dropped       <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (cfg_color_we)
                solid_color <= cfg_color;
            if (frame_req && state != ST_IDLE)
                req_dropped <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state             <= ST_STREAM;
                        w_q               <= cfg_width;
                        h_q               <= cfg_height;
                        pat_q             <= cfg_pattern;
                        x                 <= 16'd0;
                        y                 <= 16'd0;
                        m_axis_vid_tdata  <= word_nxt;
                        m_axis_vid_tvalid <= 1'b1;
                        m_axis_vid_tuser  <= 1'b1;
                        m_axis_vid_tlast  <= (cfg_width == 16'd1);
                    end
                end
                ST_STREAM: begin
                    // Without a transfer every output register holds, keeping stalls stable.
                    if (xfer) begin
                        if (last) begin
                            state             <= ST_DONE;
                            m_axis_vid_tdata  <= 32'h0;
                            m_axis_vid_tvalid <= 1'b0;
                            m_axis_vid_tlast  <= 1'b0;
                            m_axis_vid_tuser  <= 1'b0;
                            frame_done        <= 1'b1;
                            frame_count       <= frame_count + 16'd1;
                        end else begin
                            x                <= x_nxt;
                            y                <= y_nxt;
                            m_axis_vid_tdata <= word_nxt;
                            m_axis_vid_tuser <= 1'b0;
                            m_axis_vid_tlast <= (x_nxt == w_q - 16'd1);
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_video_stream_source.sv
// Directed bench for video_stream_source: frame shape, patterns, stalls, config
// shadowing, rejected requests and mid-frame reset.
module tb_video_stream_source;

    logic        m_axis_vid_aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        enable = 1'b0;
    logic        frame_req = 1'b0;
    logic [15:0] cfg_width = 16'd0;
    logic [15:0] cfg_height = 16'd0;
    logic [1:0]  cfg_pattern = 2'd0;
    logic [31:0] cfg_color = 32'h0;
    logic        cfg_color_we = 1'b0;
    logic        m_axis_vid_tready = 1'b1;
    logic [31:0] m_axis_vid_tdata;
    logic        m_axis_vid_tvalid, m_axis_vid_tlast, m_axis_vid_tuser;
    logic        frame_done, busy, req_dropped;
    logic [15:0] frame_count;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] bd [64];
    logic        bl [64];
    logic        bu [64];
    int          nbeats, done_gap, stall_bad;
    bit          done_seen;

    video_stream_source #(.BAR_SHIFT(2)) dut (
        .m_axis_vid_aclk  (m_axis_vid_aclk),
        .aresetn          (aresetn),
        .enable           (enable),
        .frame_req        (frame_req),
        .cfg_width        (cfg_width),
        .cfg_height       (cfg_height),
        .cfg_pattern      (cfg_pattern),
        .cfg_color        (cfg_color),
        .cfg_color_we     (cfg_color_we),
        .m_axis_vid_tdata (m_axis_vid_tdata),
        .m_axis_vid_tvalid(m_axis_vid_tvalid),
        .m_axis_vid_tready(m_axis_vid_tready),
        .m_axis_vid_tlast (m_axis_vid_tlast),
        .m_axis_vid_tuser (m_axis_vid_tuser),
        .frame_done       (frame_done),
        .frame_count      (frame_count),
        .busy             (busy),
        .req_dropped      (req_dropped)
    );

    always #5 m_axis_vid_aclk = ~m_axis_vid_aclk;

    // Samples #1 after each rising edge; records accepted beats until frame_done.
    task automatic collect(input int max_cyc, input bit rnd);
        logic [31:0] hd;
        logic        hl, hu;
        bit          held, rdy;
        int          last_c;
        nbeats = 0; done_seen = 0; stall_bad = 0; done_gap = -1;
        held = 0; last_c = 0; hd = '0; hl = 0; hu = 0;
        for (int c = 0; c < max_cyc && !done_seen; c++) begin
            if (frame_done) begin
                done_seen = 1;
                done_gap  = c - last_c;
            end else begin
                if (held && {m_axis_vid_tdata, m_axis_vid_tlast, m_axis_vid_tuser} !== {hd, hl, hu})
                    stall_bad++;
                rdy = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
                m_axis_vid_tready = rdy;
                held = 0;
                if (m_axis_vid_tvalid && rdy) begin
                    if (nbeats < 64) begin
                        bd[nbeats] = m_axis_vid_tdata;
                        bl[nbeats] = m_axis_vid_tlast;
                        bu[nbeats] = m_axis_vid_tuser;
                    end
                    nbeats++;
                    last_c = c;
                end else if (m_axis_vid_tvalid) begin
                    held = 1;
                    hd = m_axis_vid_tdata; hl = m_axis_vid_tlast; hu = m_axis_vid_tuser;
                end
                @(posedge m_axis_vid_aclk); #1;
            end
        end
        m_axis_vid_tready = 1'b1;
    endtask

    task automatic pulse_req();
        @(posedge m_axis_vid_aclk); #1;
        frame_req = 1'b1;
        @(posedge m_axis_vid_aclk); #1;
        frame_req = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        n_cmp++; if (m_axis_vid_tvalid !== 1'b0) begin n_bad++; $display("FAIL reset_tvalid got=%0b exp=0", m_axis_vid_tvalid); end
        n_cmp++; if (m_axis_vid_tdata !== 32'h0) begin n_bad++; $display("FAIL reset_tdata got=%h exp=0", m_axis_vid_tdata); end
        n_cmp++; if ({m_axis_vid_tlast, m_axis_vid_tuser, frame_done} !== 3'b000) begin n_bad++; $display("FAIL reset_flags got=%b exp=000", {m_axis_vid_tlast, m_axis_vid_tuser, frame_done}); end
        n_cmp++; if (frame_count !== 16'd0) begin n_bad++; $display("FAIL reset_count got=%0d exp=0", frame_count); end
        n_cmp++; if ({busy, req_dropped} !== 2'b00) begin n_bad++; $display("FAIL reset_busy_drop got=%b exp=00", {busy, req_dropped}); end
        aresetn = 1'b1;
        @(posedge m_axis_vid_aclk); #1;
        n_cmp++; if ({m_axis_vid_tvalid, busy} !== 2'b00) begin n_bad++; $display("FAIL post_reset_idle got=%b exp=00", {m_axis_vid_tvalid, busy}); end
    endtask

    task automatic test_solid();
        cfg_color = 32'h00123456; cfg_color_we = 1'b1;
        @(posedge m_axis_vid_aclk); #1;
        cfg_color_we = 1'b0;
        cfg_width = 16'd4; cfg_height = 16'd2; cfg_pattern = 2'd0; enable = 1'b1;
        pulse_req();
        collect(60, 0);
        n_cmp++; if (done_seen !== 1'b1) begin n_bad++; $display("FAIL solid_done got=%0b exp=1", done_seen); end
        n_cmp++; if (nbeats != 8) begin n_bad++; $display("FAIL solid_beats got=%0d exp=8", nbeats); end
        for (int i = 0; i < 8; i++) begin
            n_cmp++; if (bd[i] !== 32'h00123456) begin n_bad++; $display("FAIL solid_data[%0d] got=%h exp=00123456", i, bd[i]); end
            n_cmp++; if (bu[i] !== (i == 0)) begin n_bad++; $display("FAIL solid_tuser[%0d] got=%0b exp=%0b", i, bu[i], i == 0); end
            n_cmp++; if (bl[i] !== (i % 4 == 3)) begin n_bad++; $display("FAIL solid_tlast[%0d] got=%0b exp=%0b", i, bl[i], i % 4 == 3); end
        end
        n_cmp++; if (done_gap != 1) begin n_bad++; $display("FAIL solid_done_gap got=%0d exp=1", done_gap); end
        n_cmp++; if (frame_count !== 16'd1) begin n_bad++; $display("FAIL solid_count got=%0d exp=1", frame_count); end
        n_cmp++; if (m_axis_vid_tvalid !== 1'b0) begin n_bad++; $display("FAIL solid_done_tvalid got=%0b exp=0", m_axis_vid_tvalid); end
    endtask

    task automatic test_bars();
        logic [31:0] bars_exp [4];
        bars_exp = '{32'h0, 32'h000000FF, 32'h0000FF00, 32'h0000FFFF};
        cfg_width = 16'd16; cfg_height = 16'd1; cfg_pattern = 2'd3;
        pulse_req();
        collect(60, 0);
        n_cmp++; if (nbeats != 16) begin n_bad++; $display("FAIL bars_beats got=%0d exp=16", nbeats); end
        for (int i = 0; i < 16; i++) begin
            n_cmp++; if (bd[i] !== bars_exp[i / 4]) begin n_bad++; $display("FAIL bars_data[%0d] got=%h exp=%h", i, bd[i], bars_exp[i / 4]); end
            n_cmp++; if (bl[i] !== (i == 15)) begin n_bad++; $display("FAIL bars_tlast[%0d] got=%0b exp=%0b", i, bl[i], i == 15); end
        end
        n_cmp++; if (frame_count !== 16'd2) begin n_bad++; $display("FAIL bars_count got=%0d exp=2", frame_count); end
    endtask

    task automatic test_stall();
        cfg_width = 16'd3; cfg_height = 16'd3; cfg_pattern = 2'd1;
        pulse_req();
        collect(400, 1);
        n_cmp++; if (nbeats != 9) begin n_bad++; $display("FAIL stall_beats got=%0d exp=9", nbeats); end
        n_cmp++; if (stall_bad != 0) begin n_bad++; $display("FAIL stall_stable got=%0d exp=0 changes", stall_bad); end
        n_cmp++; if (bd[0] !== 32'h00000000) begin n_bad++; $display("FAIL stall_beat00 got=%h exp=00000000", bd[0]); end
        n_cmp++; if (bd[4] !== 32'h00010100) begin n_bad++; $display("FAIL stall_beat11 got=%h exp=00010100", bd[4]); end
        n_cmp++; if (bd[5] !== 32'h00020103) begin n_bad++; $display("FAIL stall_beat21 got=%h exp=00020103", bd[5]); end
        n_cmp++; if (bd[8] !== 32'h00020200) begin n_bad++; $display("FAIL stall_beat22 got=%h exp=00020200", bd[8]); end
        for (int i = 0; i < 9; i++) begin
            n_cmp++; if ({bl[i], bu[i]} !== {i % 3 == 2, i == 0}) begin n_bad++; $display("FAIL stall_flags[%0d] got=%b exp=%b", i, {bl[i], bu[i]}, {i % 3 == 2, i == 0}); end
        end
        n_cmp++; if (frame_count !== 16'd3) begin n_bad++; $display("FAIL stall_count got=%0d exp=3", frame_count); end
    endtask

    task automatic test_cfg_change();
        cfg_width = 16'd4; cfg_height = 16'd2; cfg_pattern = 2'd0;
        n_cmp++; if (req_dropped !== 1'b0) begin n_bad++; $display("FAIL drop_before got=%0b exp=0", req_dropped); end
        pulse_req();
        cfg_width = 16'd8;
        fork
            collect(60, 0);
            begin
                repeat (2) @(posedge m_axis_vid_aclk);
                #1 frame_req = 1'b1;
                @(posedge m_axis_vid_aclk);
                #1 frame_req = 1'b0;
            end
        join
        n_cmp++; if (nbeats != 8) begin n_bad++; $display("FAIL shadow_beats got=%0d exp=8", nbeats); end
        n_cmp++; if ({bl[3], bl[4], bl[7]} !== 3'b101) begin n_bad++; $display("FAIL shadow_tlast got=%b exp=101", {bl[3], bl[4], bl[7]}); end
        n_cmp++; if (req_dropped !== 1'b1) begin n_bad++; $display("FAIL drop_set got=%0b exp=1", req_dropped); end
        pulse_req();
        collect(80, 0);
        n_cmp++; if (nbeats != 16) begin n_bad++; $display("FAIL wide_beats got=%0d exp=16", nbeats); end
        n_cmp++; if ({bl[3], bl[7], bl[15]} !== 3'b011) begin n_bad++; $display("FAIL wide_tlast got=%b exp=011", {bl[3], bl[7], bl[15]}); end
        n_cmp++; if (frame_count !== 16'd5) begin n_bad++; $display("FAIL wide_count got=%0d exp=5", frame_count); end
    endtask

    task automatic test_no_start();
        cfg_width = 16'd4; cfg_height = 16'd0;
        pulse_req();
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if ({m_axis_vid_tvalid, busy} !== 2'b00) begin n_bad++; $display("FAIL zero_h[%0d] got=%b exp=00", i, {m_axis_vid_tvalid, busy}); end
            @(posedge m_axis_vid_aclk); #1;
        end
        cfg_height = 16'd2; enable = 1'b0;
        pulse_req();
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if ({m_axis_vid_tvalid, busy} !== 2'b00) begin n_bad++; $display("FAIL disabled[%0d] got=%b exp=00", i, {m_axis_vid_tvalid, busy}); end
            @(posedge m_axis_vid_aclk); #1;
        end
        n_cmp++; if (frame_count !== 16'd5) begin n_bad++; $display("FAIL no_start_count got=%0d exp=5", frame_count); end
        n_cmp++; if (req_dropped !== 1'b1) begin n_bad++; $display("FAIL drop_sticky got=%0b exp=1", req_dropped); end
        enable = 1'b1;
    endtask

    task automatic test_reset_mid();
        cfg_width = 16'd4; cfg_height = 16'd4; cfg_pattern = 2'd0;
        m_axis_vid_tready = 1'b1;
        pulse_req();
        repeat (5) begin @(posedge m_axis_vid_aclk); #1; end
        n_cmp++; if (m_axis_vid_tvalid !== 1'b1) begin n_bad++; $display("FAIL mid_tvalid got=%0b exp=1", m_axis_vid_tvalid); end
        aresetn = 1'b0;
        #1;
        n_cmp++; if ({m_axis_vid_tvalid, busy, req_dropped} !== 3'b000) begin n_bad++; $display("FAIL async_reset got=%b exp=000", {m_axis_vid_tvalid, busy, req_dropped}); end
        n_cmp++; if (frame_count !== 16'd0) begin n_bad++; $display("FAIL async_reset_count got=%0d exp=0", frame_count); end
        #2 aresetn = 1'b1;
        pulse_req();
        n_cmp++; if ({m_axis_vid_tvalid, m_axis_vid_tuser} !== 2'b11) begin n_bad++; $display("FAIL restart_first got=%b exp=11", {m_axis_vid_tvalid, m_axis_vid_tuser}); end
        n_cmp++; if (m_axis_vid_tdata !== 32'h00FF00FF) begin n_bad++; $display("FAIL restart_fill got=%h exp=00ff00ff", m_axis_vid_tdata); end
        collect(80, 0);
        n_cmp++; if (nbeats != 16) begin n_bad++; $display("FAIL restart_beats got=%0d exp=16", nbeats); end
        n_cmp++; if (frame_count !== 16'd1) begin n_bad++; $display("FAIL restart_count got=%0d exp=1", frame_count); end
    endtask

    initial begin
        test_reset();
        test_solid();
        test_bars();
        test_stall();
        test_cfg_change();
        test_no_start();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/video_stream_source.md
Name: video_stream_source

Overview:
- AXI4-Stream video source feeding the scanout/line-buffer stage's m_axis_vid_* input. Stands in for the VDMA during bring-up and for on-board self-test.
- Generates 32-bit words (one packed pixel group per word), raster order. tuser marks the first word of each frame; tlast marks the last word of each line.
- Frames are started by a request pulse, typically the scanout vsync, so source frames stay aligned to the display.

Parameters:
- BAR_SHIFT, 4, colour-bar index = x[BAR_SHIFT+2:BAR_SHIFT]
- CHECK_SHIFT, 3, checkerboard tile = 2^CHECK_SHIFT words/lines
- FILL_COLOR, 32'h00FF00FF, reset value of solid_color

Ports:
- m_axis_vid_aclk, in, 1: sole clock
- aresetn, in, 1: asynchronous active-low reset
- enable, in, 1: allow new frames to start
- frame_req, in, 1: one-cycle pulse requesting a frame start
- cfg_width, in, 16: words per line
- cfg_height, in, 16: lines per frame
- cfg_pattern, in, 2: 0 solid, 1 gradient, 2 checker, 3 bars
- cfg_color, in, 32: solid colour, loaded into solid_color when cfg_color_we
- cfg_color_we, in, 1: write strobe for cfg_color
- m_axis_vid_tdata, out, 32: pixel word
- m_axis_vid_tvalid, out, 1: word valid
- m_axis_vid_tready, in, 1: sink ready
- m_axis_vid_tlast, out, 1: last word of line
- m_axis_vid_tuser, out, 1: first word of frame
- frame_done, out, 1: one-cycle pulse after final word accepted
- frame_count, out, 16: frames completed, wraps
- busy, out, 1: frame in progress
- req_dropped, out, 1: sticky; frame_req seen while busy

Behaviour:
- Reset: all outputs 0. State IDLE. x=y=0. solid_color=FILL_COLOR.
- States:
  - IDLE: leave when enable && frame_req && cfg_width!=0 && cfg_height!=0.
    - On leaving, latch width/height/pattern into shadow regs; a config change mid-frame has no effect until the next frame.
    - Next cycle: STREAM, tvalid=1, tuser=1, word (0,0).
    - A zero dimension keeps the block in IDLE and the request is discarded.
  - STREAM: a word transfers when tvalid && tready.
    - While tvalid && !tready, hold tdata/tlast/tuser stable.
    - tvalid stays 1 until the last word is accepted.
  - DONE: one cycle. tvalid=0, frame_done=1, frame_count+1 mod 2^16. Then IDLE.
- Counters on each transfer:
  - x+1. When x==W-1: x=0, y+1.
  - When x==W-1 && y==H-1: go to DONE.
  - tlast = (x==W-1). tuser = (x==0 && y==0), and deasserts after the first transfer.
- Outputs are registered; the next word is computed from the next-state x/y. First word appears 1 cycle after an accepted request; sustained 1 word/cycle under tready=1.
- Patterns (x,y = current word coordinates, 16b):
  - 0: tdata = solid_color.
  - 1: tdata = {8'h00, x[7:0], y[7:0], x[7:0]^y[7:0]}.
  - 2: tdata = all-ones if x[CHECK_SHIFT]^y[CHECK_SHIFT], else 32'h0.
  - 3: bar b = x[BAR_SHIFT+2:BAR_SHIFT]. tdata = {8'h00, b[2]?FF:00, b[1]?FF:00, b[0]?FF:00} (BGR byte order, blue in [23:16]).
- cfg_color_we is accepted any time. During STREAM with pattern 0, the new colour takes effect on the next word generated, never on a held word.
- frame_req handling:
  - Sets req_dropped if it arrives in STREAM or DONE; the request itself is ignored.
  - req_dropped clears only on reset.
- enable low mid-frame: the current frame completes normally, then the block stays in IDLE.
- Width 1: every word has tlast=1. Height 1 frame = W words.
- frame_req and DONE in the same cycle: ignored, and sets req_dropped.
- aresetn low mid-frame: tvalid drops immediately (asynchronous). The partial frame is abandoned; the sink resynchronises on the next tuser.
- busy = (state != IDLE).

Decomposition:
- Shared package video_pkg:
  - pattern codes PAT_SOLID/PAT_GRAD/PAT_CHECK/PAT_BARS.
  - state encoding.
  - CMODE_* and OP_* constants shared with the scanout stage.
- Sub-module video_pattern_gen: combinational x,y,pattern,solid_color -> 32b word. Reused by the scanout stage for its test overlay.

Test Plan:
- W=4,H=2, pattern 0, color 32'h00123456, tready=1 -> 8 beats all 32'h00123456; tuser on beat 0; tlast on beats 3,7; frame_done 1 cycle after beat 7; frame_count=1.
- W=16,H=1, pattern 3, BAR_SHIFT=2 -> beats 0-3 tdata 0, beats 4-7 32'h000000FF, beats 12-15 32'h0000FFFF.
- W=3,H=3, pattern 1, random tready (~50%) -> tdata/tlast/tuser stable across every stall; 9 transfers; beat (2,1) = 32'h00020103.
- Change cfg_width 4->8 and pulse frame_req mid-frame -> current frame stays 4 words/line; req_dropped=1; next frame 8 words/line.
- cfg_height=0 with frame_req -> no tvalid, busy=0; enable=0 with frame_req -> no frame starts.
- aresetn low at beat 5 of a 4x4 frame -> tvalid=0 the same cycle, frame_count=0; after release plus frame_req, tuser on the first beat.
